lcd_stream_rx: RTL and testbench
================================

// Module: lcd_stream_rx
// PURPOSE
//  Receiver/capture end of the RGB565 LCD pixel interface (ce + hsync/vsync/de + 16b data) generated by the parrot video top.
//  Samples the stream on pixel-enable cycles, measures frame geometry, locks onto it, and emits per-pixel write strobes with
//  x/y coordinates for a downstream framebuffer/scaler. Flags geometry changes. Sits in the clk36m domain beside the colour LUT.
// PARAMETERS
//  XW       10   width of x counters/measurements (max 1023)
//  YW       9    width of y counters/measurements (max 511)
//  HS_POL   0    hsync active level (0 = active-low)
//  VS_POL   0    vsync active level (0 = active-low)
//  MAX_W    480  pixels per line accepted; pixels with x >= MAX_W are dropped
//  MAX_H    272  lines accepted; lines with y >= MAX_H are dropped
// PORTS
//  clk36m      in   1    system/video clock
//  i_res_n     in   1    reset, synchronous, active-low
//  ce_pix      in   1    pixel enable (1 clk36m pulse per pixel, 9 MHz rate); inputs below valid only when high
//  lcd_hsync   in   1    horizontal sync, polarity HS_POL
//  lcd_vsync   in   1    vertical sync, polarity VS_POL
//  lcd_de      in   1    data enable, active-high
//  lcd_data    in   16   RGB565 pixel
//  pix_we      out  1    captured pixel write strobe (1 cycle)
//  pix_x       out  XW   pixel column
//  pix_y       out  YW   pixel row
//  pix_data    out  16   pixel RGB565
//  frame_start out  1    1-cycle pulse on vsync assertion edge
//  locked      out  1    geometry locked, capture active
//  geom_err    out  1    1-cycle pulse: locked frame geometry differed from stored
//  overflow    out  1    sticky: a pixel/line exceeded MAX_W/MAX_H; cleared by reset only
//  meas_hact   out  XW   locked active pixels per line
//  meas_vact   out  YW   locked active lines per frame
//  meas_htotal out  XW+1 locked ce_pix count between hsync assertion edges
// BEHAVIOUR
//  Reset (i_res_n=0 at clk36m edge): all outputs 0, state SEARCH, counters 0. Reset mid-frame discards the frame.
//  Clock gating: all state advances only on cycles with ce_pix=1; outputs registered, latency 1 clk36m after the ce_pix cycle.
//  Sync normalisation: hs/vs XOR'd to active-high; edge = active now & inactive at previous ce_pix sample.
//  Counters: x resets to 0 on DE rising, +1 per DE-high sample; y resets on vsync edge, +1 on DE falling; h counter resets on hs edge.
//  Widths: counters saturate at all-ones, never wrap; saturation sets overflow.
//  FSM:
//   SEARCH : wait vsync edge -> MEASURE.
//   MEASURE: count one full frame; at next vsync edge store hact (x at last DE fall), vact (y), htotal -> LOCKED.
//            If vact==0 or hact==0 at that edge, stay MEASURE (restart count).
//   LOCKED : locked=1; each DE-high sample with x<MAX_W and y<MAX_H -> pix_we=1, pix_x=x, pix_y=y, pix_data=lcd_data.
//            At each vsync edge compare frame hact/vact/htotal with stored; mismatch -> geom_err pulse, locked=0, -> MEASURE.
//  Simultaneous vsync edge and DE high on same sample: vsync processed first (y=0), pixel captured as row 0.
//  frame_start pulses on every vsync edge in every state. DE inconsistent line length within a frame -> hact of last line used.
//  No pix_we ever outside LOCKED; pix_x/pix_y/pix_data hold last value when pix_we=0.
// STRUCTURE
//  party_video_pkg: rx_state_t enum {SEARCH,MEASURE,LOCKED}; LCD_HACT=480, LCD_VACT=272, LCD_HTOTAL=525, LCD_VTOTAL=286.
//  Sub-module lcd_sync_edge: polarity normalise + ce-qualified rising-edge detect, instanced for hsync, vsync, de.
//  Top of block: counters, measurement regs, FSM, output register stage.
// TESTING
//  1 Reset then 480x272 stream (htotal 525, vtotal 286, active-low syncs) -> locked=1 after 2nd vsync edge; meas 480/272/525.
//  2 Locked frame -> exactly 130560 pix_we pulses; first (0,0), last (479,271); pix_data equals driven pattern x^y.
//  3 Switch to 320 active pixels/line while locked -> geom_err one pulse at next vsync, locked=0, relock with hact=320 next frame.
//  4 Stream with 500 px/line, MAX_W=480 -> x 480..499 never written; overflow=0 (below saturation); hact=500 stored.
//  5 Assert i_res_n=0 mid-line for 3 cycles -> all outputs 0 next edge; SEARCH; no pix_we until relock after 2 vsync edges.
//  6 ce_pix held low 10 cycles with DE high -> no counter change, no pix_we; vsync+DE same sample -> pixel at row 0.

Source files
------------

// File: rtl/party_video_pkg.sv
// Shared types and nominal panel geometry for the parrot LCD video path.
package party_video_pkg;

    localparam int LCD_HACT   = 480;
    localparam int LCD_VACT   = 272;
    localparam int LCD_HTOTAL = 525;
    localparam int LCD_VTOTAL = 286;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/lcd_sync_edge.sv
// Polarity-normalised level plus ce-qualified edge detect for one LCD control line.
module lcd_sync_edge
    import party_video_pkg::*;
#(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    assign level = sig ^ ~POL;
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else if (ce) begin
            prev <= level;
        end
    end

endmodule

// File: rtl/lcd_stream_rx.sv
// RGB565 LCD stream capture: measures frame geometry, locks, emits pixel strobes.
module lcd_stream_rx
    import party_video_pkg::*;
#(
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int MAX_W  = LCD_HACT,
    parameter int MAX_H  = LCD_VACT
) (
    input  logic          clk36m,
    input  logic          i_res_n,
    input  logic          ce_pix,
    input  logic          lcd_hsync,
    input  logic          lcd_vsync,
    input  logic          lcd_de,
    input  logic [15:0]   lcd_data,
    output logic          pix_we,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [15:0]   pix_data,
    output logic          frame_start,
    output logic          locked,
    output logic          geom_err,
    output logic          overflow,
    output logic [XW-1:0] meas_hact,
    output logic [YW-1:0] meas_vact,
    output logic [XW:0]   meas_htotal
);

    localparam logic [XW:0] W_LIM = (XW+1)'(MAX_W);
    localparam logic [YW:0] H_LIM = (YW+1)'(MAX_H);

    logic hs_rise, vs_rise, de_lvl, de_rise, de_fall;
    logic hs_lvl_unused, hs_fall_unused, vs_lvl_unused, vs_fall_unused;

    lcd_sync_edge #(.POL(HS_POL)) u_hs (
        .clk(clk36m), .rst_n(i_res_n), .ce(ce_pix), .sig(lcd_hsync),
        .level(hs_lvl_unused), .rise(hs_rise), .fall(hs_fall_unused)
    );
    lcd_sync_edge #(.POL(VS_POL)) u_vs (
        .clk(clk36m), .rst_n(i_res_n), .ce(ce_pix), .sig(lcd_vsync),
        .level(vs_lvl_unused), .rise(vs_rise), .fall(vs_fall_unused)
    );
    lcd_sync_edge #(.POL(1'b1)) u_de (
        .clk(clk36m), .rst_n(i_res_n), .ce(ce_pix), .sig(lcd_de),
        .level(de_lvl), .rise(de_rise), .fall(de_fall)
    );

    rx_state_t     state;
    logic [XW-1:0] x_cnt, hact_f, cur_x, hact_cur;
    logic [YW-1:0] y_cnt, cur_y;
    logic [XW:0]   h_cnt, htot_f, htot_cur;
    logic          x_sat, y_sat, h_sat, geom_bad, capture;

    // Sync edges take effect on the sample they arrive with.
    always_comb begin
        cur_x    = de_rise ? '0 : x_cnt;
        cur_y    = vs_rise ? '0 : y_cnt;
        hact_cur = de_fall ? x_cnt : hact_f;
        htot_cur = hs_rise ? h_cnt : htot_f;
        x_sat    = de_lvl && (cur_x == '1);
        y_sat    = de_fall && (cur_y == '1);
        h_sat    = !hs_rise && (h_cnt == '1);
        geom_bad = (hact_cur != meas_hact) || (y_cnt != meas_vact)
                || (htot_cur != meas_htotal);
        capture  = de_lvl && (state == LOCKED)
                && ({1'b0, cur_x} < W_LIM) && ({1'b0, cur_y} < H_LIM)
                && !(vs_rise && geom_bad);
    end

    always_ff @(posedge clk36m) begin
        if (!i_res_n) begin
            state       <= SEARCH;
            x_cnt       <= '0;
            y_cnt       <= '0;
            h_cnt       <= '0;
            hact_f      <= '0;
            htot_f      <= '0;
            pix_we      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            geom_err    <= 1'b0;
            overflow    <= 1'b0;
            meas_hact   <= '0;
            meas_vact   <= '0;
            meas_htotal <= '0;
        end else begin
            pix_we      <= 1'b0;
            frame_start <= 1'b0;
            geom_err    <= 1'b0;
            if (ce_pix) begin
                if (de_lvl) x_cnt <= x_sat ? cur_x : cur_x + 1'b1;
                if (de_fall) y_cnt <= y_sat ? cur_y : cur_y + 1'b1;
                else         y_cnt <= cur_y;
                if (hs_rise) begin
                    h_cnt  <= (XW+1)'(1);
                    htot_f <= h_cnt;
                end else if (!h_sat) begin
                    h_cnt <= h_cnt + 1'b1;
                end
                if (vs_rise)      hact_f <= '0;
                else if (de_fall) hact_f <= x_cnt;
                if (x_sat || y_sat || h_sat) overflow <= 1'b1;
                frame_start <= vs_rise;

                case (state)
                    SEARCH: begin
                        if (vs_rise) state <= MEASURE;
                    end
                    MEASURE: begin
                        if (vs_rise && hact_cur != '0 && y_cnt != '0) begin
                            meas_hact   <= hact_cur;
                            meas_vact   <= y_cnt;
                            meas_htotal <= htot_cur;
                            locked      <= 1'b1;
                            state       <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (vs_rise && geom_bad) begin
                            geom_err <= 1'b1;
                            locked   <= 1'b0;
                            state    <= MEASURE;
                        end
                    end
                    default: state <= SEARCH;
                endcase

                if (capture) begin
                    pix_we   <= 1'b1;
                    pix_x    <= cur_x;
                    pix_y    <= cur_y;
                    pix_data <= lcd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_stream_rx.sv
// Scenario bench for lcd_stream_rx using small frame geometries and random ce gaps.
module tb_lcd_stream_rx;

    localparam int BW  = 32;
    localparam int BH  = 20;
    localparam int HSW = 4;
    localparam int HBP = 6;

    logic        clk = 1'b0;
    logic        rst_n, ce, hs, vs, de;
    logic [15:0] data;
    logic        pix_we, frame_start, locked, geom_err, overflow;
    logic [9:0]  pix_x, meas_hact;
    logic [8:0]  pix_y, meas_vact;
    logic [15:0] pix_data;
    logic [10:0] meas_htotal;

    always #5 clk = ~clk;

    lcd_stream_rx #(
        .XW(10), .YW(9), .HS_POL(1'b0), .VS_POL(1'b0), .MAX_W(BW), .MAX_H(BH)
    ) dut (
        .clk36m(clk), .i_res_n(rst_n), .ce_pix(ce),
        .lcd_hsync(hs), .lcd_vsync(vs), .lcd_de(de), .lcd_data(data),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_start(frame_start), .locked(locked), .geom_err(geom_err),
        .overflow(overflow), .meas_hact(meas_hact), .meas_vact(meas_vact),
        .meas_htotal(meas_htotal)
    );

    typedef struct {
        int          x;
        int          y;
        logic [15:0] d;
    } pix_t;

    pix_t got[$];
    int   total = 0;
    int   bad = 0;
    int   ge_cnt = 0;
    int   fs_cnt = 0;
    bit   gaps_on = 1'b1;

    always @(negedge clk) begin
        if (pix_we) got.push_back('{int'(pix_x), int'(pix_y), pix_data});
        if (geom_err) ge_cnt++;
        if (frame_start) fs_cnt++;
    end

    function automatic logic [15:0] pat(input int x, input int y, input logic [15:0] seed);
        return 16'(x ^ (y << 6)) ^ seed;
    endfunction

    // One ce sample, then optional idle cycles carrying junk inputs.
    task automatic sample(input logic h, input logic v, input logic d, input logic [15:0] px);
        int n;
        ce = 1'b1; hs = h; vs = v; de = d; data = px;
        @(posedge clk); #1;
        n = gaps_on ? $urandom_range(0, 1) : 0;
        repeat (n) begin
            ce = 1'b0; hs = 1'($urandom); vs = 1'($urandom);
            de = 1'($urandom); data = 16'($urandom);
            @(posedge clk); #1;
        end
        ce = 1'b0;
    endtask

    task automatic send_frame(input int hact, input int vact, input int htot, input int vtot,
                              input int vs_off, input int vbp, input int gap_line,
                              input logic [15:0] seed);
        bit hs_a, vs_a, de_a;
        int dx, dl;
        got.delete();
        for (int l = 0; l < vtot; l++) begin
            for (int s = 0; s < htot; s++) begin
                hs_a = (s < HSW);
                vs_a = (l == 0 && s >= vs_off) || (l == 1 && s < vs_off);
                dl = l - vbp;
                dx = s - HBP;
                de_a = (dl >= 0) && (dl < vact) && (dx >= 0) && (dx < hact);
                sample(~hs_a, ~vs_a, de_a, de_a ? pat(dx, dl, seed) : 16'($urandom));
                if (l == gap_line && s == HBP + 3) begin
                    ce = 1'b0; de = 1'b1; data = 16'($urandom);
                    repeat (10) @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_pixels(input string name, input int hact, input int vact,
                                input logic [15:0] seed, input bit expect_cap);
        int nx, ny, n, idx;
        bit ok;
        nx = (hact < BW) ? hact : BW;
        ny = (vact < BH) ? vact : BH;
        n = expect_cap ? nx * ny : 0;
        total++;
        if (got.size() != n) begin
            bad++;
            $display("FAIL %s pixel count: got %0d need %0d", name, got.size(), n);
        end else if (n > 0) begin
            ok = 1'b1;
            idx = 0;
            for (int y = 0; y < ny; y++) begin
                for (int x = 0; x < nx; x++) begin
                    if (ok && (got[idx].x != x || got[idx].y != y ||
                               got[idx].d !== pat(x, y, seed))) begin
                        ok = 1'b0;
                        $display("FAIL %s pixel %0d: got (%0d,%0d,%h) need (%0d,%0d,%h)",
                                 name, idx, got[idx].x, got[idx].y, got[idx].d,
                                 x, y, pat(x, y, seed));
                    end
                    idx++;
                end
            end
            total++;
            if (!ok) bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({pix_we, pix_x, pix_y, pix_data, frame_start, locked, geom_err, overflow,
             meas_hact, meas_vact, meas_htotal} !== '0) begin
            bad++;
            $display("FAIL reset outputs: locked=%b we=%b hact=%0d ovf=%b need all 0",
                     locked, pix_we, meas_hact, overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        got.delete();
        fs_cnt = 0;
        ge_cnt = 0;
    endtask

    task automatic test_lock();
        logic [15:0] sd;
        sd = 16'($urandom);
        send_frame(24, 12, 40, 16, 0, 2, -1, sd);
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL lock_first_frame locked: got %b need 0", locked);
        end
        check_pixels("lock_first_frame", 24, 12, sd, 1'b0);
        sd = 16'($urandom);
        send_frame(24, 12, 40, 16, 0, 2, -1, sd);
        total++;
        if (locked !== 1'b1) begin
            bad++; $display("FAIL lock_second locked: got %b need 1", locked);
        end
        total++;
        if (meas_hact !== 10'd24 || meas_vact !== 9'd12 || meas_htotal !== 11'd40) begin
            bad++;
            $display("FAIL lock_meas: got %0d/%0d/%0d need 24/12/40",
                     meas_hact, meas_vact, meas_htotal);
        end
        total++;
        if (fs_cnt != 2) begin
            bad++; $display("FAIL lock_frame_start count: got %0d need 2", fs_cnt);
        end
        check_pixels("lock_capture", 24, 12, sd, 1'b1);
    endtask

    task automatic test_ce_gap();
        logic [15:0] sd;
        sd = 16'($urandom);
        send_frame(24, 12, 40, 16, HBP, 0, 3, sd);
        check_pixels("ce_gap_row0", 24, 12, sd, 1'b1);
        total++;
        if (locked !== 1'b1 || ge_cnt != 0) begin
            bad++;
            $display("FAIL ce_gap_lock: got locked=%b gerr=%0d need 1/0", locked, ge_cnt);
        end
    endtask

    task automatic test_geom_change();
        logic [15:0] sd;
        sd = 16'($urandom);
        send_frame(16, 12, 40, 16, 0, 2, -1, sd);
        check_pixels("geom_first_narrow", 16, 12, sd, 1'b1);
        total++;
        if (ge_cnt != 0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL geom_first_narrow: got gerr=%0d locked=%b need 0/1", ge_cnt, locked);
        end
        sd = 16'($urandom);
        send_frame(16, 12, 40, 16, 0, 2, -1, sd);
        total++;
        if (ge_cnt != 1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL geom_err pulse: got gerr=%0d locked=%b need 1/0", ge_cnt, locked);
        end
        check_pixels("geom_unlocked", 16, 12, sd, 1'b0);
        sd = 16'($urandom);
        send_frame(16, 12, 40, 16, 0, 2, -1, sd);
        total++;
        if (locked !== 1'b1 || meas_hact !== 10'd16 || ge_cnt != 1) begin
            bad++;
            $display("FAIL geom_relock: got locked=%b hact=%0d gerr=%0d need 1/16/1",
                     locked, meas_hact, ge_cnt);
        end
        check_pixels("geom_relock", 16, 12, sd, 1'b1);
    endtask

    task automatic test_max_clip();
        logic [15:0] sd;
        sd = 16'($urandom);
        send_frame(40, 22, 52, 26, 0, 2, -1, sd);
        check_pixels("clip_old_lock", 40, 22, sd, 1'b1);
        sd = 16'($urandom);
        send_frame(40, 22, 52, 26, 0, 2, -1, sd);
        check_pixels("clip_unlocked", 40, 22, sd, 1'b0);
        sd = 16'($urandom);
        send_frame(40, 22, 52, 26, 0, 2, -1, sd);
        check_pixels("clip_relock", 40, 22, sd, 1'b1);
        total++;
        if (meas_hact !== 10'd40 || meas_vact !== 9'd22 || meas_htotal !== 11'd52) begin
            bad++;
            $display("FAIL clip_meas: got %0d/%0d/%0d need 40/22/52",
                     meas_hact, meas_vact, meas_htotal);
        end
        total++;
        if (overflow !== 1'b0 || ge_cnt != 2) begin
            bad++;
            $display("FAIL clip_flags: got ovf=%b gerr=%0d need 0/2", overflow, ge_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] sd;
        for (int i = 0; i < 10; i++) sample(1'b1, 1'b1, 1'b1, 16'($urandom));
        rst_n = 1'b0; ce = 1'b1; de = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({pix_we, pix_x, pix_y, pix_data, frame_start, locked, geom_err, overflow,
             meas_hact, meas_vact, meas_htotal} !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: locked=%b we=%b hact=%0d need all 0",
                     locked, pix_we, meas_hact);
        end
        got.delete();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (got.size() != 0) begin
            bad++; $display("FAIL reset_mid strobes: got %0d need 0", got.size());
        end
        rst_n = 1'b1; ce = 1'b0; de = 1'b0; hs = 1'b1; vs = 1'b1;
        sd = 16'($urandom);
        send_frame(24, 12, 40, 16, 0, 2, -1, sd);
        check_pixels("reset_mid_measure", 24, 12, sd, 1'b0);
        sd = 16'($urandom);
        send_frame(24, 12, 40, 16, 0, 2, -1, sd);
        check_pixels("reset_mid_relock", 24, 12, sd, 1'b1);
        total++;
        if (locked !== 1'b1 || meas_hact !== 10'd24) begin
            bad++;
            $display("FAIL reset_mid_lock: got locked=%b hact=%0d need 1/24", locked, meas_hact);
        end
    endtask

    task automatic test_overflow();
        gaps_on = 1'b0;
        sample(1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 1023; i++) sample(1'b1, 1'b1, 1'b1, 16'($urandom));
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL overflow_below_sat: got %b need 0", overflow);
        end
        sample(1'b1, 1'b1, 1'b1, 16'($urandom));
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL overflow_at_sat: got %b need 1", overflow);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_ce_gap();
        test_geom_change();
        test_max_clip();
        test_reset_mid();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
